// File: rtl/axi_err_capture.sv
// Passive AXI4 error monitor: tracks outstanding requests by ID, captures the
// first errored R/B response, keeps saturating error counters and per-hart irqs.
module axi_err_capture #(
    parameter int unsigned IdWidth   = 5,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned UserWidth = 2,
    parameter int unsigned NumHarts  = 4,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ar_valid_i,
    input  logic                 ar_ready_i,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [UserWidth-1:0] ar_user_i,
    input  logic                 aw_valid_i,
    input  logic                 aw_ready_i,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic [UserWidth-1:0] aw_user_i,
    input  logic                 r_valid_i,
    input  logic                 r_ready_i,
    input  logic                 r_last_i,
    input  logic [IdWidth-1:0]   r_id_i,
    input  logic [1:0]           r_resp_i,
    input  logic                 b_valid_i,
    input  logic                 b_ready_i,
    input  logic [IdWidth-1:0]   b_id_i,
    input  logic [1:0]           b_resp_i,
    input  logic                 clear_i,
    output logic                 err_valid_o,
    output logic                 err_is_write_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic [IdWidth-1:0]   err_id_o,
    output logic [1:0]           err_resp_o,
    output logic [UserWidth-1:0] err_hart_o,
    output logic                 overflow_o,
    output logic [CntWidth-1:0]  r_err_cnt_o,
    output logic [CntWidth-1:0]  b_err_cnt_o,
    output logic [NumHarts-1:0]  irq_o
);

    localparam int unsigned Depth = 2 ** IdWidth;

    logic [Depth-1:0]     rd_vld_q, rd_vld_d;
    logic [Depth-1:0]     wr_vld_q, wr_vld_d;
    logic [Depth-1:0]     rerr_q, rerr_d;
    logic [AddrWidth-1:0] rd_addr_q [Depth];
    logic [AddrWidth-1:0] wr_addr_q [Depth];
    logic [UserWidth-1:0] rd_user_q [Depth];
    logic [UserWidth-1:0] wr_user_q [Depth];

    logic                 ar_hs_c, aw_hs_c, r_hs_c, b_hs_c;
    logic                 r_err_c, b_err_c, r_txn_err_c;
    logic                 cap_free_c, r_load_c, b_load_c, ovf_set_c;
    logic [AddrWidth-1:0] ld_addr_c;
    logic [UserWidth-1:0] ld_hart_c;
    logic [NumHarts-1:0]  hart_onehot_c;

    assign ar_hs_c = ar_valid_i & ar_ready_i;
    assign aw_hs_c = aw_valid_i & aw_ready_i;
    assign r_hs_c  = r_valid_i & r_ready_i;
    assign b_hs_c  = b_valid_i & b_ready_i;
    // SLVERR and DECERR both have resp[1] set
    assign r_err_c = r_hs_c & r_resp_i[1];
    assign b_err_c = b_hs_c & b_resp_i[1];
    assign r_txn_err_c = r_hs_c & r_last_i & (rerr_q[r_id_i] | r_err_c);

    // Completions retire the old entry before a same-cycle request reinstalls it
    always_comb begin
        rd_vld_d = rd_vld_q;
        wr_vld_d = wr_vld_q;
        rerr_d   = rerr_q;
        if (r_hs_c) begin
            if (r_last_i) begin
                rerr_d[r_id_i]   = 1'b0;
                rd_vld_d[r_id_i] = 1'b0;
            end else begin
                rerr_d[r_id_i] = rerr_q[r_id_i] | r_err_c;
            end
        end
        if (b_hs_c) begin
            wr_vld_d[b_id_i] = 1'b0;
        end
        if (ar_hs_c) begin
            rd_vld_d[ar_id_i] = 1'b1;
        end
        if (aw_hs_c) begin
            wr_vld_d[aw_id_i] = 1'b1;
        end
    end

    // Capture selection: R beats take priority over B in the same cycle
    always_comb begin
        cap_free_c = ~err_valid_o | clear_i;
        r_load_c   = r_err_c & cap_free_c;
        b_load_c   = b_err_c & cap_free_c & ~r_err_c;
        ovf_set_c  = (r_err_c & b_err_c) | ((r_err_c | b_err_c) & ~cap_free_c);
        ld_addr_c  = '0;
        ld_hart_c  = '0;
        if (r_load_c) begin
            if (rd_vld_q[r_id_i]) begin
                ld_addr_c = rd_addr_q[r_id_i];
                ld_hart_c = rd_user_q[r_id_i];
            end
        end else if (wr_vld_q[b_id_i]) begin
            ld_addr_c = wr_addr_q[b_id_i];
            ld_hart_c = wr_user_q[b_id_i];
        end
        hart_onehot_c = '0;
        for (int h = 0; h < int'(NumHarts); h++) begin
            hart_onehot_c[h] = (ld_hart_c == UserWidth'(h));
        end
    end

    // Table payload carries no reset; valid bits qualify every read
    always_ff @(posedge clk_i) begin
        if (ar_hs_c) begin
            rd_addr_q[ar_id_i] <= ar_addr_i;
            rd_user_q[ar_id_i] <= ar_user_i;
        end
        if (aw_hs_c) begin
            wr_addr_q[aw_id_i] <= aw_addr_i;
            wr_user_q[aw_id_i] <= aw_user_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_vld_q <= '0;
            wr_vld_q <= '0;
            rerr_q   <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            wr_vld_q <= wr_vld_d;
            rerr_q   <= rerr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_o    <= 1'b0;
            err_is_write_o <= 1'b0;
            err_addr_o     <= '0;
            err_id_o       <= '0;
            err_resp_o     <= '0;
            err_hart_o     <= '0;
            overflow_o     <= 1'b0;
            irq_o          <= '0;
        end else begin
            if (clear_i) begin
                err_valid_o <= 1'b0;
                overflow_o  <= 1'b0;
                irq_o       <= '0;
            end
            if (r_load_c || b_load_c) begin
                err_valid_o    <= 1'b1;
                err_is_write_o <= b_load_c;
                err_addr_o     <= ld_addr_c;
                err_id_o       <= r_load_c ? r_id_i : b_id_i;
                err_resp_o     <= r_load_c ? r_resp_i : b_resp_i;
                err_hart_o     <= ld_hart_c;
                irq_o          <= hart_onehot_c;
            end
            if (ovf_set_c) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Saturating counters, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt_o <= '0;
            b_err_cnt_o <= '0;
        end else begin
            if (r_txn_err_c && (r_err_cnt_o != '1)) begin
                r_err_cnt_o <= r_err_cnt_o + CntWidth'(1);
            end
            if (b_err_c && (b_err_cnt_o != '1)) begin
                b_err_cnt_o <= b_err_cnt_o + CntWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_axi_err_capture.sv
// Directed + randomized bench for axi_err_capture with a transaction-level model.
module tb_axi_err_capture;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ar_valid_i, ar_ready_i, aw_valid_i, aw_ready_i;
    logic [4:0]  ar_id_i, aw_id_i, r_id_i, b_id_i;
    logic [63:0] ar_addr_i, aw_addr_i;
    logic [1:0]  ar_user_i, aw_user_i;
    logic        r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i;
    logic [1:0]  r_resp_i, b_resp_i;
    logic        clear_i;
    logic        err_valid_o, err_is_write_o, overflow_o;
    logic [63:0] err_addr_o;
    logic [4:0]  err_id_o;
    logic [1:0]  err_resp_o, err_hart_o;
    logic [15:0] r_err_cnt_o, b_err_cnt_o;
    logic [3:0]  irq_o;

    axi_err_capture dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ar_valid_i(ar_valid_i), .ar_ready_i(ar_ready_i), .ar_id_i(ar_id_i),
        .ar_addr_i(ar_addr_i), .ar_user_i(ar_user_i),
        .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i), .aw_id_i(aw_id_i),
        .aw_addr_i(aw_addr_i), .aw_user_i(aw_user_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
        .r_id_i(r_id_i), .r_resp_i(r_resp_i),
        .b_valid_i(b_valid_i), .b_ready_i(b_ready_i), .b_id_i(b_id_i), .b_resp_i(b_resp_i),
        .clear_i(clear_i),
        .err_valid_o(err_valid_o), .err_is_write_o(err_is_write_o), .err_addr_o(err_addr_o),
        .err_id_o(err_id_o), .err_resp_o(err_resp_o), .err_hart_o(err_hart_o),
        .overflow_o(overflow_o), .r_err_cnt_o(r_err_cnt_o), .b_err_cnt_o(b_err_cnt_o),
        .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: outstanding requests by ID and the observable capture state
    bit          m_rv [32];
    bit          m_wv [32];
    bit          m_rerr [32];
    logic [63:0] m_ra [32];
    logic [63:0] m_wa [32];
    int          m_ru [32];
    int          m_wu [32];
    bit          m_ev, m_isw, m_ov;
    logic [63:0] m_addr;
    int          m_id, m_resp, m_hart, m_rcnt, m_bcnt;
    logic [3:0]  m_irq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_rv[i] = 0; m_wv[i] = 0; m_rerr[i] = 0;
        end
        m_ev = 0; m_isw = 0; m_ov = 0; m_addr = 0; m_id = 0; m_resp = 0;
        m_hart = 0; m_rcnt = 0; m_bcnt = 0; m_irq = 0;
    endtask

    task automatic model_load(input bit is_w, input int id, input int resp);
        bit hit;
        hit    = is_w ? m_wv[id] : m_rv[id];
        m_ev   = 1;
        m_isw  = is_w;
        m_id   = id;
        m_resp = resp;
        m_addr = hit ? (is_w ? m_wa[id] : m_ra[id]) : 64'd0;
        m_hart = hit ? (is_w ? m_wu[id] : m_ru[id]) : 0;
        m_irq  = (m_hart < 4) ? (4'b0001 << m_hart) : 4'b0000;
    endtask

    // Apply one clock's worth of bus activity to the model
    task automatic model_step();
        bit r_hs, b_hs, r_e, b_e, free;
        r_hs = r_valid_i && r_ready_i;
        b_hs = b_valid_i && b_ready_i;
        r_e  = r_hs && (r_resp_i >= 2);
        b_e  = b_hs && (b_resp_i >= 2);
        free = !m_ev || clear_i;
        if (clear_i) begin
            m_ev = 0; m_ov = 0; m_irq = 0;
        end
        if (r_e && free) begin
            model_load(0, int'(r_id_i), int'(r_resp_i));
            if (b_e) m_ov = 1;
        end else if (b_e && free) begin
            model_load(1, int'(b_id_i), int'(b_resp_i));
        end else if (r_e || b_e) begin
            m_ov = 1;
        end
        if (r_hs) begin
            if (r_last_i) begin
                if (m_rerr[r_id_i] || r_e) m_rcnt = (m_rcnt < 65535) ? m_rcnt + 1 : 65535;
                m_rerr[r_id_i] = 0;
                m_rv[r_id_i]   = 0;
            end else if (r_e) begin
                m_rerr[r_id_i] = 1;
            end
        end
        if (b_hs) begin
            if (b_e) m_bcnt = (m_bcnt < 65535) ? m_bcnt + 1 : 65535;
            m_wv[b_id_i] = 0;
        end
        if (ar_valid_i && ar_ready_i) begin
            m_rv[ar_id_i] = 1; m_ra[ar_id_i] = ar_addr_i; m_ru[ar_id_i] = int'(ar_user_i);
        end
        if (aw_valid_i && aw_ready_i) begin
            m_wv[aw_id_i] = 1; m_wa[aw_id_i] = aw_addr_i; m_wu[aw_id_i] = int'(aw_user_i);
        end
    endtask

    task automatic idle();
        ar_valid_i = 0; ar_ready_i = 1; ar_id_i = 0; ar_addr_i = 0; ar_user_i = 0;
        aw_valid_i = 0; aw_ready_i = 1; aw_id_i = 0; aw_addr_i = 0; aw_user_i = 0;
        r_valid_i = 0; r_ready_i = 1; r_last_i = 0; r_id_i = 0; r_resp_i = 0;
        b_valid_i = 0; b_ready_i = 1; b_id_i = 0; b_resp_i = 0;
        clear_i = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
        idle();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".err_valid"}, 64'(err_valid_o), 64'(m_ev));
        chk({tag, ".overflow"}, 64'(overflow_o), 64'(m_ov));
        chk({tag, ".irq"}, 64'(irq_o), 64'(m_irq));
        chk({tag, ".r_cnt"}, 64'(r_err_cnt_o), 64'(m_rcnt));
        chk({tag, ".b_cnt"}, 64'(b_err_cnt_o), 64'(m_bcnt));
        if (m_ev) begin
            chk({tag, ".is_write"}, 64'(err_is_write_o), 64'(m_isw));
            chk({tag, ".addr"}, err_addr_o, m_addr);
            chk({tag, ".id"}, 64'(err_id_o), 64'(m_id));
            chk({tag, ".resp"}, 64'(err_resp_o), 64'(m_resp));
            chk({tag, ".hart"}, 64'(err_hart_o), 64'(m_hart));
        end
    endtask

    task automatic issue_ar(input int id, input logic [63:0] addr, input int user);
        ar_valid_i = 1; ar_id_i = 5'(id); ar_addr_i = addr; ar_user_i = 2'(user);
        tick();
    endtask

    task automatic issue_aw(input int id, input logic [63:0] addr, input int user);
        aw_valid_i = 1; aw_id_i = 5'(id); aw_addr_i = addr; aw_user_i = 2'(user);
        tick();
    endtask

    task automatic r_beat(input int id, input int resp, input bit last);
        r_valid_i = 1; r_id_i = 5'(id); r_resp_i = 2'(resp); r_last_i = last;
        tick();
    endtask

    task automatic do_clear();
        clear_i = 1;
        tick();
    endtask

    initial begin
        idle();
        model_reset();
        rst_ni = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check_all("reset");
        chk("reset.addr0", err_addr_o, 64'd0);
        rst_ni = 1;

        // 4-beat read, second beat SLVERR
        issue_ar(3, 64'h8000_1000, 2);
        r_beat(3, 0, 0);
        r_beat(3, 2, 0);
        check_all("rd_err");
        chk("rd_err.addr_const", err_addr_o, 64'h8000_1000);
        chk("rd_err.irq_const", 64'(irq_o), 64'h4);
        chk("rd_err.cnt_mid", 64'(r_err_cnt_o), 64'd0);
        r_beat(3, 0, 0);
        r_beat(3, 0, 1);
        chk("rd_err.cnt_last", 64'(r_err_cnt_o), 64'd1);
        check_all("rd_done");
        do_clear();
        check_all("clear1");

        // Write DECERR
        issue_aw(7, 64'h1C00_0000, 0);
        b_valid_i = 1; b_id_i = 5'd7; b_resp_i = 2'b11;
        tick();
        check_all("wr_err");
        chk("wr_err.is_write_const", 64'(err_is_write_o), 64'd1);
        chk("wr_err.irq_const", 64'(irq_o), 64'h1);
        do_clear();

        // Same-cycle R and B errors
        issue_ar(1, 64'hA000_0040, 1);
        issue_aw(2, 64'hB000_0080, 3);
        r_valid_i = 1; r_id_i = 5'd1; r_resp_i = 2'b11; r_last_i = 1;
        b_valid_i = 1; b_id_i = 5'd2; b_resp_i = 2'b10;
        tick();
        check_all("both");
        chk("both.overflow_const", 64'(overflow_o), 64'd1);
        chk("both.is_read_const", 64'(err_is_write_o), 64'd0);
        do_clear();

        // B with no matching AW
        b_valid_i = 1; b_id_i = 5'd9; b_resp_i = 2'b11;
        tick();
        check_all("miss");
        chk("miss.addr_const", err_addr_o, 64'd0);
        chk("miss.hart_const", 64'(err_hart_o), 64'd0);
        do_clear();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            ar_valid_i = 1'($urandom); ar_ready_i = 1'($urandom); ar_id_i = 5'($urandom_range(0, 7));
            ar_addr_i = {$urandom, $urandom}; ar_user_i = 2'($urandom);
            aw_valid_i = 1'($urandom); aw_ready_i = 1'($urandom); aw_id_i = 5'($urandom_range(0, 7));
            aw_addr_i = {$urandom, $urandom}; aw_user_i = 2'($urandom);
            r_valid_i = 1'($urandom); r_ready_i = 1'($urandom); r_id_i = 5'($urandom_range(0, 7));
            r_resp_i = 2'($urandom); r_last_i = ($urandom_range(0, 2) == 0);
            b_valid_i = 1'($urandom); b_ready_i = 1'($urandom); b_id_i = 5'($urandom_range(0, 7));
            b_resp_i = 2'($urandom);
            clear_i = ($urandom_range(0, 15) == 0);
            tick();
            check_all("rand");
        end

        // Drive the write counter into saturation
        for (int n = 0; n < 65536; n++) begin
            b_valid_i = 1; b_id_i = 5'($urandom); b_resp_i = 2'b11;
            tick();
        end
        check_all("sat");
        chk("sat.b_cnt_const", 64'(b_err_cnt_o), 64'hFFFF);
        b_valid_i = 1; b_id_i = 5'd4; b_resp_i = 2'b10;
        tick();
        chk("sat.hold", 64'(b_err_cnt_o), 64'hFFFF);

        // Clear coincident with a new read error
        issue_ar(4, 64'h0000_0123_4567_8000, 1);
        clear_i = 1;
        r_valid_i = 1; r_id_i = 5'd4; r_resp_i = 2'b10; r_last_i = 1;
        tick();
        check_all("clr_new");
        chk("clr_new.addr_const", err_addr_o, 64'h0000_0123_4567_8000);
        chk("clr_new.ovf_const", 64'(overflow_o), 64'd0);
        chk("clr_new.irq_const", 64'(irq_o), 64'h2);

        // Reset in the middle of an errored burst
        issue_ar(5, 64'h5555_0000, 3);
        r_beat(5, 2, 0);
        rst_ni = 0;
        #1;
        model_reset();
        check_all("mid_rst");
        @(posedge clk_i);
        #1;
        rst_ni = 1;
        r_beat(5, 0, 1);
        check_all("post_rst");
        chk("post_rst.r_cnt_const", 64'(r_err_cnt_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_err_capture.md
Name: axi_err_capture

Overview:
- Passive AXI4 monitor on the host-domain master port, between the ID remapper and the CDC source. Supersedes the simulation-only R/B error warnings with synthesisable error logging.
- Tracks the address and hart of every outstanding transaction by ID.
- Captures the first DECERR/SLVERR response (address, ID, direction, hart), counts errored transactions and raises a per-hart interrupt.
- Never drives the bus; all AXI signals are inputs.

Parameters:
- IdWidth, 5, AXI ID width; the tracking tables have 2**IdWidth entries.
- AddrWidth, 64, AXI address width.
- UserWidth, 2, AXI user width; user carries the originating hart index.
- NumHarts, 4, number of hart interrupt lines; must satisfy NumHarts <= 2**UserWidth.
- CntWidth, 16, width of the saturating error counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ar_valid_i, ar_ready_i  in  1 each  AR handshake
- ar_id_i  in  IdWidth  AR ID
- ar_addr_i  in  AddrWidth  AR address
- ar_user_i  in  UserWidth  AR user/hart
- aw_valid_i, aw_ready_i, aw_id_i, aw_addr_i, aw_user_i  in  as AR  AW channel
- r_valid_i, r_ready_i, r_last_i  in  1 each  R handshake and last beat
- r_id_i  in  IdWidth  R ID
- r_resp_i  in  2  R response
- b_valid_i, b_ready_i  in  1 each  B handshake
- b_id_i  in  IdWidth  B ID
- b_resp_i  in  2  B response
- clear_i  in  1  single-cycle pulse: release capture, clear overflow and irqs
- err_valid_o  out  1  capture registers hold an error
- err_is_write_o  out  1  captured error came from B (1) or R (0)
- err_addr_o  out  AddrWidth  address of the faulting transaction
- err_id_o  out  IdWidth  ID of the faulting transaction
- err_resp_o  out  2  captured response code
- err_hart_o  out  UserWidth  hart of the faulting transaction
- overflow_o  out  1  an error arrived while err_valid_o=1
- r_err_cnt_o  out  CntWidth  errored read transactions
- b_err_cnt_o  out  CntWidth  errored write transactions
- irq_o  out  NumHarts  per-hart level interrupt

Behaviour:
- Reset: all outputs 0; table valid bits and per-ID read-error flags 0. Table payload is not reset.
- Error response: resp == DECERR (2'b11) or SLVERR (2'b10). OKAY and EXOKAY are not errors.
- Tables: a separate read table and write table, indexed by ID, each entry {valid, addr, user}.
  - AR handshake writes the read table at ar_id_i and sets valid.
  - AW handshake writes the write table at aw_id_i and sets valid.
  - Handshake means valid & ready in the same cycle.
  - The system guarantees at most one outstanding transaction per ID per direction. A second AR/AW to a valid entry overwrites it.
- Read burst tracking, per ID (one flag per ID):
  - On every R handshake, OR the error into rerr[r_id_i].
  - On r_last_i, the transaction is errored if rerr or the current beat is an error. Clear rerr and the table valid bit.
  - The read counter increments once per errored transaction, on the last beat.
- Write: each B handshake completes the transaction. Increment the write counter if errored; clear valid.
- Counters saturate at all-ones. They do not wrap and are not cleared by clear_i; only reset clears them.
- Capture:
  - The first error beat (R beat of any position, or B) with err_valid_o=0 loads the capture registers one cycle after the handshake and sets err_valid_o.
  - Address and hart come from the table entry.
  - If the table entry is not valid (response with no request), capture err_addr_o = 0 and err_hart_o = 0; still counted.
- Simultaneous R and B error beats in one cycle: R is captured, B sets overflow_o; both are counted.
- Any error while err_valid_o=1 (or in the same cycle it becomes 1) sets overflow_o; the capture is not altered.
- irq_o[h] is set in the cycle err_valid_o rises, for h = captured hart. It is a level and stays set until clear_i. Harts >= NumHarts raise no irq.
- clear_i pulse:
  - Next cycle: err_valid_o, overflow_o and irq_o are 0.
  - An error handshake in the same cycle as clear_i is captured fresh, so the clear wins for the old capture and the new error loads.
- Simultaneous AR and R on the same ID: the R completion is processed against the old entry, then the new AR is written; the new entry remains valid.
- Reset mid-burst: all tracking is lost. Responses arriving after reset are treated as table misses.
- Latency: capture, irq and counters update on the clock edge ending the handshake cycle (outputs visible 1 cycle later).

Test Plan:
- AR id=3 addr=0x8000_1000 user=2; 4-beat R with beat 2 SLVERR -> err_valid_o=1, err_addr_o=0x8000_1000, err_id_o=3, err_resp_o=2'b10, err_hart_o=2, irq_o=4'b0100; r_err_cnt_o=1 after the last beat only.
- AW id=7 addr=0x1C00_0000 user=0; B DECERR -> err_is_write_o=1, err_resp_o=2'b11, b_err_cnt_o=1, irq_o=4'b0001.
- Same-cycle R error (id 1) and B error (id 2) -> R captured, overflow_o=1, both counters +1.
- B DECERR with id 9 never issued on AW -> err_addr_o=0, err_hart_o=0, b_err_cnt_o=1.
- Force b_err_cnt_o to 16'hFFFF via 65535 errored writes, then one more -> it stays 16'hFFFF. Pulse clear_i together with a new R error -> old capture replaced by the new one, overflow_o=0.
- Assert rst_ni=0 mid-burst after an errored beat -> all outputs 0. A post-reset OKAY last beat increments no counter.
